// File: rtl/stream_mux_rr_if.sv
// Handshake bundle for stream_mux_rr: N producer channels in, one registered stream out.
// The slave modport is the mux; the master modport is whoever drives producers and consumer.
interface stream_mux_rr_if #(
   parameter int NCH   = 4,
   parameter int WIDTH = 8
);
   localparam int SELW = (NCH <= 2) ? 1 : $clog2(NCH);

   logic                 mode;
   logic [SELW-1:0]      sel;
   logic [NCH*WIDTH-1:0] in_data;
   logic [NCH-1:0]       in_valid;
   logic [NCH-1:0]       in_last;
   logic [NCH-1:0]       in_ready;
   logic [WIDTH-1:0]     out_data;
   logic [SELW-1:0]      out_ch;
   logic                 out_valid;
   logic                 out_ready;

   modport master (
      output mode, sel, in_data, in_valid, in_last, out_ready,
      input  in_ready, out_data, out_ch, out_valid
   );

   modport slave (
      input  mode, sel, in_data, in_valid, in_last, out_ready,
      output in_ready, out_data, out_ch, out_valid
   );
endinterface

// File: rtl/stream_mux_rr.sv
// Registered N-to-1 stream mux with manual select or round-robin arbitration.
// Optional packet lock in round-robin mode when STREAM_MUX_LOCK_EN is defined.
module stream_mux_rr #(
   parameter int NCH   = 4,
   parameter int WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   stream_mux_rr_if.slave bus
);
   localparam int SELW = (NCH <= 2) ? 1 : $clog2(NCH);
   localparam int NSEL = 1 << SELW;

   logic [WIDTH-1:0] r_out_data;
   logic [SELW-1:0]  r_out_ch;
   logic             r_out_valid;
   logic [SELW-1:0]  r_rr_ptr;

   logic             w_load;
   logic             w_accept;
   logic             w_has_win;
   logic [SELW-1:0]  w_win;
   logic             w_rr_found;
   logic [SELW-1:0]  w_rr_win;
   logic [SELW-1:0]  w_idx;
   logic             w_lock;
   logic [NSEL-1:0]  w_valid_ext;
   logic [WIDTH-1:0] w_chan [NCH];

   // Zero-padded valid vector so an out-of-range manual sel never finds a winner.
   generate
      if (NCH < NSEL) begin : g_pad
         assign w_valid_ext = {{(NSEL-NCH){1'b0}}, bus.in_valid};
      end else begin : g_nopad
         assign w_valid_ext = bus.in_valid;
      end
   endgenerate

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_chan
         assign w_chan[gi]       = bus.in_data[gi*WIDTH +: WIDTH];
         assign bus.in_ready[gi] = w_load && w_has_win && (w_win == SELW'(gi));
      end
   endgenerate

   // Round-robin search starts one past the last granted channel.
   always_comb begin
      w_rr_found = 1'b0;
      w_rr_win   = r_rr_ptr;
      w_idx      = r_rr_ptr;
      for (int k = 1; k <= NCH; k++) begin
         w_idx = SELW'((int'(r_rr_ptr) + k) % NCH);
         if (!w_rr_found && bus.in_valid[w_idx]) begin
            w_rr_found = 1'b1;
            w_rr_win   = w_idx;
         end
      end
   end

   always_comb begin
      w_win     = bus.sel;
      w_has_win = w_valid_ext[bus.sel];
      if (bus.mode) begin
         if (w_lock) begin
            w_win     = r_rr_ptr;
            w_has_win = 1'b1;
         end else begin
            w_win     = w_rr_win;
            w_has_win = w_rr_found;
         end
      end
   end

   assign w_load   = !r_out_valid || bus.out_ready;
   assign w_accept = w_load && w_has_win && bus.in_valid[w_win];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_data  <= '0;
         r_out_ch    <= '0;
         r_out_valid <= 1'b0;
         r_rr_ptr    <= SELW'(NCH-1);
      end else if (w_load) begin
         if (w_accept) begin
            r_out_data  <= w_chan[w_win];
            r_out_ch    <= w_win;
            r_out_valid <= 1'b1;
            r_rr_ptr    <= w_win;
         end else begin
            r_out_valid <= 1'b0;
         end
      end
   end

`ifdef STREAM_MUX_LOCK_EN
   // While locked, the locked channel is always r_rr_ptr since only it can be accepted.
   logic r_lock;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lock <= 1'b0;
      end else if (!bus.mode) begin
         r_lock <= 1'b0;
      end else if (w_accept) begin
         r_lock <= !bus.in_last[w_win];
      end
   end
   assign w_lock = r_lock;
`else
   wire w_unused_last = ^bus.in_last;
   assign w_lock = 1'b0;
`endif

   assign bus.out_data  = r_out_data;
   assign bus.out_ch    = r_out_ch;
   assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_stream_mux_rr.sv
// Randomized bench for stream_mux_rr (NCH=3) against a per-cycle arbitration model.
// Build with STREAM_MUX_LOCK_EN defined to exercise the packet-lock variant.
module tb_stream_mux_rr;
   localparam int NCH   = 3;
   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   stream_mux_rr_if #(.NCH(NCH), .WIDTH(WIDTH)) bus ();
   stream_mux_rr #(.NCH(NCH), .WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state: what the output register and arbiter must hold.
   bit         m_valid;
   logic [7:0] m_data;
   int         m_ch;
   int         m_ptr;
   bit         m_lock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_ch    = 0;
      m_ptr   = NCH-1;
      m_lock  = 1'b0;
   endtask

   task automatic set_data_random();
      for (int i = 0; i < NCH; i++) bus.in_data[i*WIDTH +: WIDTH] = 8'($urandom);
   endtask

   // One clock: check outputs against the model mid-cycle, then advance the model.
   task automatic step();
      int w;
      bit has, load, acc;
      logic [NCH-1:0] er;
      bit n_valid, n_lock;
      logic [7:0] n_data;
      int n_ch, n_ptr;
      @(negedge clk);
      has = 1'b0;
      w   = 0;
      if (bus.mode) begin
         if (m_lock) begin
            w   = m_ptr;
            has = 1'b1;
         end else begin
            for (int k = 1; k <= NCH; k++) begin
               int i;
               i = (m_ptr + k) % NCH;
               if (!has && bus.in_valid[i]) begin
                  has = 1'b1;
                  w   = i;
               end
            end
         end
      end else begin
         w   = int'(bus.sel);
         has = (w < NCH) && bus.in_valid[w];
      end
      load = !m_valid || bus.out_ready;
      er   = '0;
      if (load && has) er[w] = 1'b1;
      acc = load && has && bus.in_valid[w];

      chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("out_data",  32'(bus.out_data),  32'(m_data));
      chk("out_ch",    32'(bus.out_ch),    32'(m_ch));
      chk("in_ready",  32'(bus.in_ready),  32'(er));

      n_valid = m_valid; n_data = m_data; n_ch = m_ch; n_ptr = m_ptr; n_lock = m_lock;
      if (load) begin
         if (acc) begin
            n_valid = 1'b1;
            n_data  = bus.in_data[w*WIDTH +: WIDTH];
            n_ch    = w;
            n_ptr   = w;
            $display("[TB] t=%0t accept ch%0d data %02h mode %0d", $time, w, n_data, bus.mode);
         end else begin
            n_valid = 1'b0;
         end
      end
`ifdef STREAM_MUX_LOCK_EN
      if (!bus.mode) n_lock = 1'b0;
      else if (acc)  n_lock = !bus.in_last[w];
`endif
      @(posedge clk);
      #1;
      m_valid = n_valid; m_data = n_data; m_ch = n_ch; m_ptr = n_ptr; m_lock = n_lock;
   endtask

   initial begin
      int exp2 [4];
      int exp6 [4];
      exp2 = '{0, 1, 2, 0};
`ifdef STREAM_MUX_LOCK_EN
      exp6 = '{1, 1, 1, 2};
`else
      exp6 = '{1, 2, 0, 1};
`endif
      bus.mode      = 1'b0;
      bus.sel       = '0;
      bus.in_data   = '0;
      bus.in_valid  = '0;
      bus.in_last   = '1;
      bus.out_ready = 1'b0;
      model_reset();
      #12;
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_data",  32'(bus.out_data),  32'd0);
      chk("rst_ch",    32'(bus.out_ch),    32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Manual select of channel 2.
      bus.mode = 1'b0; bus.sel = 2'd2; bus.in_valid = 3'b100;
      bus.in_data[2*WIDTH +: WIDTH] = 8'hA5; bus.out_ready = 1'b1;
      step();
      chk("t1_valid", 32'(bus.out_valid), 32'd1);
      chk("t1_data",  32'(bus.out_data),  32'hA5);
      chk("t1_ch",    32'(bus.out_ch),    32'd2);

      // Round-robin with every channel requesting: one word per clock, rotating.
      bus.mode = 1'b1; bus.in_valid = 3'b111;
      for (int i = 0; i < 4; i++) begin
         set_data_random();
         step();
         chk("t2_ch", 32'(bus.out_ch), 32'(exp2[i]));
         chk("t2_valid", 32'(bus.out_valid), 32'd1);
      end

      // Consumer stall holds everything, then resumes without a bubble.
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         set_data_random();
         step();
         chk("t3_ready", 32'(bus.in_ready), 32'd0);
         chk("t3_ch",    32'(bus.out_ch),   32'd0);
      end
      bus.out_ready = 1'b1;
      step();
      chk("t3_resume_ch",    32'(bus.out_ch),    32'd1);
      chk("t3_resume_valid", 32'(bus.out_valid), 32'd1);

      // Out-of-range manual select: no winner, output drains.
      bus.mode = 1'b0; bus.sel = 2'd3;
      step();
      chk("t4_ready", 32'(bus.in_ready),  32'd0);
      chk("t4_valid", 32'(bus.out_valid), 32'd0);

      // Asynchronous reset mid-stream, then channel 0 gets the first grant.
      bus.mode = 1'b1; bus.in_valid = 3'b111;
      step();
      chk("t5_pre_valid", 32'(bus.out_valid), 32'd1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("t5_async_valid", 32'(bus.out_valid), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();
      chk("t5_first_ch", 32'(bus.out_ch), 32'd0);

      // Channel 1 sends a three-word packet while channels 0 and 2 also request.
      for (int i = 0; i < 4; i++) begin
         set_data_random();
         bus.in_last = {1'b1, (i == 2), 1'b1};
         step();
         chk("t6_ch", 32'(bus.out_ch), 32'(exp6[i]));
      end

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 15) == 0) bus.mode = ~bus.mode;
         bus.sel       = 2'($urandom_range(0, 3));
         bus.in_valid  = 3'($urandom);
         bus.in_last   = 3'($urandom);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         set_data_random();
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
